ate_stream: RTL and testbench
=============================

Name: ate_stream

Overview:
- Parametrised adaptive-threshold binarisation engine for block-raster pixel streams.
- Each block of BLK_PIX pixels is buffered while its min/max are tracked. The block is then binarised against ceil((max+min)/2) while the next block fills.
- Adds valid handshaking, a flush path for the last block, and configurable pixel width, block size and border handling.
- Sits between the pixel source and the downstream bitmap packer.

Parameters:
- PIX_W, 8, pixel bit width (≥2).
- BLK_PIX, 64, pixels per block; power of two, 4..256.
- BLKS_PER_ROW, 6, blocks per block-row (≥3).
- BORDER_ZERO, 1, 1 = first and last block of each block-row forced to bin=0 and threshold=0; 0 = all blocks processed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  pix_data valid this cycle; no backpressure, the block always accepts.
- pix_data  in  PIX_W  input pixel, block-raster order.
- flush  in  1  single-cycle pulse: drain the buffered block without new input.
- out_valid  out  1  bin/threshold valid.
- bin  out  1  binarised pixel.
- threshold  out  PIX_W  threshold applied to the current output block.
- blk_last  out  1  high with the final out_valid pixel of a block.
- busy  out  1  high while flushing.

Behaviour:
- Reset values: out_valid=0, bin=0, threshold=0, blk_last=0, busy=0.
- Reset clears all counters, the block column, state, and the ping-pong bank select. Buffer contents are don't-care.
- Reset mid-block discards all partial data; the next accepted pixel is pixel 0 of block 0.
- Storage: two banks of BLK_PIX×PIX_W (ping-pong).
- A write index advances only on in_valid and wraps at BLK_PIX-1.
- Min/max tracking:
  - On pixel index 0 of a block, running min and max load pix_data.
  - On later pixels, running min/max update on ≤ / ≥ comparisons.
- End of block (accepted pixel with index BLK_PIX-1):
  - Threshold computed with a PIX_W+1-bit sum: (max+min+1)>>1, i.e. odd sums round up.
  - The threshold latches into the pending register together with that block's column.
  - The bank select toggles.
  - The block column increments and wraps at BLKS_PER_ROW-1.
- States:
  - FIRST: no complete block is held yet. After the first block completes, go to STREAM.
  - STREAM: a complete block is held.
    - Each accepted input pixel at index k causes output of buffered pixel k of the held block on the next cycle: out_valid=1, bin = (buf[k] ≥ threshold).
    - On a pulse of flush while in_valid=0 and write index=0, go to FLUSH.
  - FLUSH:
    - busy=1; one output per cycle for k=0..BLK_PIX-1, independent of in_valid.
    - in_valid during FLUSH is ignored.
    - After k=BLK_PIX-1 go to FIRST; bank select and block column are not reset.
- Flush when not legal: flush with write index ≠0, or flush in FIRST, is ignored.
- Output block handover: the threshold output register updates when pixel 0 of a held block is emitted and stays stable for the whole block.
- Border blocks (BORDER_ZERO=1, column 0 or BLKS_PER_ROW-1): bin=0 and threshold=0. Output timing is unchanged.
- blk_last=1 coincident with output k=BLK_PIX-1.
- Latency: the output for input pixel p of block N appears one cycle after pixel p of block N+1 is accepted, or during FLUSH.
- Equal min=max: threshold = that value; every pixel gives bin=1.

Optional Feature:
- Macro: ATE_STREAM_MINMAX_EN.
- Defined: adds outputs blk_min and blk_max, each PIX_W wide. They hold the min and max of the current output block and update with threshold at pixel 0. They are forced to 0 for border blocks when BORDER_ZERO=1.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, 6 blocks of ramp 0..63, BORDER_ZERO=1 → blocks 0 and 5 give bin=0 and threshold=0. Blocks 1–4 give threshold 32 (0+63=63, rounds up). bin=0 for pixels 0..31 and bin=1 for 32..63.
- Block with min=10, max=20 → threshold 15. Pixel 14 gives bin=0; pixels 15 and 20 give bin=1.
- in_valid gapped with a random 50% duty → output count and order match the gap-free run. out_valid rises exactly one cycle after each accepted pixel.
- Flush after block 2 (column 2) completes → 64 consecutive out_valid cycles with busy=1. blk_last fires on the 64th. State returns to FIRST; the next block is column 3.
- Reset asserted at pixel 37 of block 1 → all outputs go to 0 immediately. The next 64 pixels form block 0 with no output until block 1 streams.
- PIX_W=10, BLK_PIX=16, BORDER_ZERO=0, min=1022 and max=1023 → threshold 1023 (no overflow). Pixel 1022 gives bin=0.

Source files
------------

// File: rtl/ate_stream.sv
// rtl/ate_stream.sv - adaptive-threshold binarisation of block-raster pixel streams (ping-pong block buffer)
// Optional blk_min/blk_max outputs: define ATE_STREAM_MINMAX_EN.
module ate_stream #(
    parameter int PIX_W        = 8,
    parameter int BLK_PIX      = 64,
    parameter int BLKS_PER_ROW = 6,
    parameter int BORDER_ZERO  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             flush,
    output logic             out_valid,
    output logic             bin,
    output logic [PIX_W-1:0] threshold,
    output logic             blk_last,
    output logic             busy
`ifdef ATE_STREAM_MINMAX_EN
    ,
    output logic [PIX_W-1:0] blk_min,
    output logic [PIX_W-1:0] blk_max
`endif
);

    localparam int AW = $clog2(BLK_PIX);
    localparam int CW = $clog2(BLKS_PER_ROW);
    localparam logic [1:0] S_FIRST  = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [AW-1:0] IDX_LAST = AW'(BLK_PIX - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(BLKS_PER_ROW - 1);

    logic [1:0]       state;
    logic [AW-1:0]    wr_idx, rd_idx, rd_k;
    logic             bank_sel;
    logic [CW-1:0]    col, pend_col;
    logic [PIX_W-1:0] run_min, run_max, nxt_min, nxt_max;
    logic [PIX_W-1:0] pend_thr, act_thr, cur_thr, rd_data;
    logic [PIX_W:0]   sum;
    logic             act_border, pend_border, cur_border;
    logic             accept, blk_end, emit, first_pix, flush_ok;
    logic [PIX_W-1:0] mem0 [BLK_PIX];
    logic [PIX_W-1:0] mem1 [BLK_PIX];

    always_comb begin
        accept      = in_valid && (state != S_FLUSH);
        blk_end     = accept && (wr_idx == IDX_LAST);
        nxt_min     = ((wr_idx == '0) || (pix_data <= run_min)) ? pix_data : run_min;
        nxt_max     = ((wr_idx == '0) || (pix_data >= run_max)) ? pix_data : run_max;
        sum         = {1'b0, nxt_max} + {1'b0, nxt_min} + (PIX_W+1)'(1);
        pend_border = (BORDER_ZERO != 0) && ((pend_col == '0) || (pend_col == COL_LAST));
        emit        = ((state == S_STREAM) && in_valid) || (state == S_FLUSH);
        rd_k        = (state == S_FLUSH) ? rd_idx : wr_idx;
        // The held (complete) block always lives in the bank not being written.
        rd_data     = bank_sel ? mem0[rd_k] : mem1[rd_k];
        first_pix   = (rd_k == '0);
        cur_thr     = first_pix ? pend_thr : act_thr;
        cur_border  = first_pix ? pend_border : act_border;
        flush_ok    = flush && (state == S_STREAM) && !in_valid && (wr_idx == '0);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (bank_sel) mem1[wr_idx] <= pix_data;
            else          mem0[wr_idx] <= pix_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FIRST;
            wr_idx     <= '0;
            rd_idx     <= '0;
            bank_sel   <= 1'b0;
            col        <= '0;
            pend_col   <= '0;
            run_min    <= '0;
            run_max    <= '0;
            pend_thr   <= '0;
            act_thr    <= '0;
            act_border <= 1'b0;
            out_valid  <= 1'b0;
            bin        <= 1'b0;
            threshold  <= '0;
            blk_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                wr_idx  <= wr_idx + AW'(1);
                run_min <= nxt_min;
                run_max <= nxt_max;
            end
            if (blk_end) begin
                pend_thr <= PIX_W'(sum >> 1);
                pend_col <= col;
                bank_sel <= ~bank_sel;
                col      <= (col == COL_LAST) ? '0 : col + CW'(1);
            end

            case (state)
                S_FIRST:  if (blk_end) state <= S_STREAM;
                S_STREAM: if (flush_ok) begin
                    state  <= S_FLUSH;
                    rd_idx <= '0;
                end
                S_FLUSH: begin
                    rd_idx <= rd_idx + AW'(1);
                    if (rd_idx == IDX_LAST) state <= S_FIRST;
                end
                default: state <= S_FIRST;
            endcase

            out_valid <= emit;
            blk_last  <= emit && (rd_k == IDX_LAST);
            busy      <= (state == S_FLUSH);
            bin       <= emit && !cur_border && (rd_data >= cur_thr);
            // Threshold handover happens only at pixel 0 so the whole block sees one value.
            if (emit && first_pix) begin
                threshold  <= pend_border ? '0 : pend_thr;
                act_thr    <= pend_thr;
                act_border <= pend_border;
            end
        end
    end

`ifdef ATE_STREAM_MINMAX_EN
    logic [PIX_W-1:0] pend_min, pend_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_min <= '0;
            pend_max <= '0;
            blk_min  <= '0;
            blk_max  <= '0;
        end else begin
            if (blk_end) begin
                pend_min <= nxt_min;
                pend_max <= nxt_max;
            end
            if (emit && first_pix) begin
                blk_min <= pend_border ? '0 : pend_min;
                blk_max <= pend_border ? '0 : pend_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ate_stream.sv
// tb/tb_ate_stream.sv - scoreboard bench for ate_stream (default build and a 10-bit/16-pixel variant)
module tb_ate_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       va, fa, ova, ba, bla, bya;
    logic [7:0] pa, ta;
    logic       vb, fb, ovb, bb, blb, byb;
    logic [9:0] pb, tb_thr;

    ate_stream dut_a (
        .clk(clk), .reset(reset), .in_valid(va), .pix_data(pa), .flush(fa),
        .out_valid(ova), .bin(ba), .threshold(ta), .blk_last(bla), .busy(bya)
    );

    ate_stream #(.PIX_W(10), .BLK_PIX(16), .BLKS_PER_ROW(6), .BORDER_ZERO(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(vb), .pix_data(pb), .flush(fb),
        .out_valid(ovb), .bin(bb), .threshold(tb_thr), .blk_last(blb), .busy(byb)
    );

    typedef struct {
        bit b;
        int thr;
        bit last;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   blk[2]  = '{64, 16};
    int   cols[2] = '{6, 6};
    bit   bz[2]   = '{1'b1, 1'b0};
    int   fill[2][64];
    int   hold[2][64];
    int   widx[2], col[2], hthr[2];
    bit   held[2], hbord[2];

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            widx[s] = 0;
            col[s]  = 0;
            held[s] = 1'b0;
        end
        sb.delete();
    endtask

    task automatic drive(input int sel, input bit v, input int pix, input bit fl);
        if (sel == 0) begin
            va = v; pa = pix[7:0]; fa = fl;
        end else begin
            vb = v; pb = pix[9:0]; fb = fl;
        end
    endtask

    task automatic check(input int sel, input bit exp_v, input string tag);
        logic v, b, l, y;
        logic [31:0] t;
        exp_t e;
        v = (sel == 0) ? ova : ovb;
        b = (sel == 0) ? ba  : bb;
        l = (sel == 0) ? bla : blb;
        y = (sel == 0) ? bya : byb;
        t = (sel == 0) ? 32'(ta) : 32'(tb_thr);
        cmp({tag, "_valid"}, v, exp_v);
        if (exp_v) begin
            e = sb.pop_front();
            cmp({tag, "_bin"}, b, e.b);
            cmp({tag, "_thr"}, t, e.thr);
            cmp({tag, "_last"}, l, e.last);
            cmp({tag, "_busy"}, y, e.busy);
        end else begin
            cmp({tag, "_idle_busy"}, y, 0);
        end
    endtask

    task automatic step(input int sel, input bit v, input int pix, input string tag);
        bit   ev;
        exp_t e;
        int   mn, mx;
        drive(sel, v, pix, 1'b0);
        ev = v && held[sel];
        if (ev) begin
            e.b    = !hbord[sel] && (hold[sel][widx[sel]] >= hthr[sel]);
            e.thr  = hbord[sel] ? 0 : hthr[sel];
            e.last = (widx[sel] == blk[sel] - 1);
            e.busy = 1'b0;
            sb.push_back(e);
        end
        if (v) begin
            fill[sel][widx[sel]] = pix;
            if (widx[sel] == blk[sel] - 1) begin
                mn = fill[sel][0];
                mx = fill[sel][0];
                for (int i = 0; i < blk[sel]; i++) begin
                    if (fill[sel][i] < mn) mn = fill[sel][i];
                    if (fill[sel][i] > mx) mx = fill[sel][i];
                    hold[sel][i] = fill[sel][i];
                end
                hthr[sel]  = (mn + mx + 1) / 2;
                hbord[sel] = bz[sel] && (col[sel] == 0 || col[sel] == cols[sel] - 1);
                held[sel]  = 1'b1;
                col[sel]   = (col[sel] + 1) % cols[sel];
                widx[sel]  = 0;
            end else begin
                widx[sel]++;
            end
        end
        @(posedge clk);
        #1;
        check(sel, ev, tag);
    endtask

    task automatic do_flush(input int sel, input string tag);
        bit   ok;
        exp_t e;
        ok = held[sel] && (widx[sel] == 0);
        drive(sel, 1'b0, 0, 1'b1);
        @(posedge clk);
        #1;
        check(sel, 1'b0, {tag, "_req"});
        drive(sel, 1'b0, 0, 1'b0);
        if (ok) begin
            for (int k = 0; k < blk[sel]; k++) begin
                e.b    = !hbord[sel] && (hold[sel][k] >= hthr[sel]);
                e.thr  = hbord[sel] ? 0 : hthr[sel];
                e.last = (k == blk[sel] - 1);
                e.busy = 1'b1;
                sb.push_back(e);
            end
            held[sel] = 1'b0;
            for (int k = 0; k < blk[sel]; k++) begin
                drive(sel, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0);
                @(posedge clk);
                #1;
                check(sel, 1'b1, tag);
            end
            drive(sel, 1'b0, 0, 1'b0);
        end
        @(posedge clk);
        #1;
        check(sel, 1'b0, {tag, "_after"});
    endtask

    task automatic gapped_block(input int sel, input string tag, input bit ramp);
        int k;
        k = 0;
        while (k < blk[sel]) begin
            if ($urandom_range(0, 1) == 1) begin
                step(sel, 1'b1, ramp ? k : int'($urandom_range(0, 255)), tag);
                k++;
            end else begin
                step(sel, 1'b0, 0, tag);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_valid", ova, 0);
        cmp("rst_bin", ba, 0);
        cmp("rst_thr", ta, 0);
        cmp("rst_last", bla, 0);
        cmp("rst_busy", bya, 0);
        cmp("rst_b_valid", ovb, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Six ramp blocks: columns 0 and 5 are borders, others threshold 32.
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 64; k++) begin
                step(0, 1'b1, k, "ramp");
                if (b == 2 && k == 31) begin
                    cmp("ramp_thr32", ta, 32);
                    cmp("ramp_bin31", ba, 0);
                end
                if (b == 2 && k == 32) cmp("ramp_bin32", ba, 1);
                if (b == 1 && k == 40) cmp("border_thr0", ta, 0);
            end
        end
        do_flush(0, "flush_col5");
        do_flush(0, "flush_in_first");

        for (int k = 0; k < 64; k++) step(0, 1'b1, k, "fill_col0");
        for (int k = 0; k < 64; k++) step(0, 1'b1, 10 + (k % 11), "mm_col1");
        for (int k = 0; k < 30; k++) step(0, 1'b1, int'($urandom_range(0, 255)), "col2a");
        do_flush(0, "flush_mid_block");
        for (int k = 30; k < 64; k++) begin
            step(0, 1'b1, int'($urandom_range(0, 255)), "col2b");
            if (k == 30) cmp("mm_thr15", ta, 15);
        end
        do_flush(0, "flush_col2");

        for (int k = 0; k < 64; k++) step(0, 1'b1, int'($urandom_range(0, 255)), "col3");
        gapped_block(0, "gap_col4", 1'b0);
        gapped_block(0, "gap_col5", 1'b1);
        for (int k = 0; k < 64; k++) step(0, 1'b1, k, "col0");
        for (int k = 0; k <= 37; k++) step(0, 1'b1, k, "pre_rst");

        reset = 1'b1;
        #1;
        cmp("mid_rst_valid", ova, 0);
        cmp("mid_rst_thr", ta, 0);
        cmp("mid_rst_busy", bya, 0);
        drive(0, 1'b0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < 64; k++) step(0, 1'b1, k, "post_rst");

        // Narrow variant: 10-bit pixels near full scale, then a flat block.
        for (int k = 0; k < 16; k++) step(1, 1'b1, (k % 2 == 0) ? 1022 : 1023, "b_top");
        for (int k = 0; k < 16; k++) begin
            step(1, 1'b1, 500, "b_flat");
            if (k == 0) begin
                cmp("b_thr_1023", tb_thr, 1023);
                cmp("b_bin_1022", bb, 0);
            end
            if (k == 1) cmp("b_bin_1023", bb, 1);
        end
        for (int k = 0; k < 16; k++) begin
            step(1, 1'b1, k, "b_ramp");
            if (k == 5) cmp("b_thr_500", tb_thr, 500);
        end
        do_flush(1, "b_flush");

        cmp("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
